// File: rtl/sha256_iter_core_pkg.sv
// Shared SHA-256 constants, working-state payload and round functions for the
// iterative compression core.
package sha256_iter_core_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned MSG_W  = 512;
    localparam int unsigned HASH_W = 256;
    localparam int unsigned ROUNDS = 64;
    localparam int unsigned CNT_W  = 6;

    typedef logic [WORD_W-1:0] word_t;

    // Working variables a..h; a occupies the most significant word.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } work_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    localparam work_t IV = work_t'(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);

    localparam word_t K [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Word-wise modular sum used for the chaining-value feed-forward.
    function automatic work_t add_work(input work_t x, input work_t y);
        return '{a: x.a + y.a, b: x.b + y.b, c: x.c + y.c, d: x.d + y.d,
                 e: x.e + y.e, f: x.f + y.f, g: x.g + y.g, h: x.h + y.h};
    endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// One combinational SHA-256 compression round: {a..h, K, W} -> next {a..h}.
module sha256_round_comb
    import sha256_iter_core_pkg::*;
(
    input  work_t cur,
    input  word_t k,
    input  word_t w,
    output work_t nxt_c
);

    word_t t1_c;
    word_t t2_c;

    always_comb begin
        t1_c  = cur.h + bsig1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
        t2_c  = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);
        nxt_c = '{a: t1_c + t2_c, b: cur.a, c: cur.b, d: cur.c,
                  e: cur.d + t1_c, f: cur.e, g: cur.f, h: cur.g};
    end

endmodule

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core, UNROLL rounds per clock, with optional
// second pass (sha256d) reusing the same round chain.
module sha256_iter_core
    import sha256_iter_core_pkg::*;
#(
    parameter int unsigned UNROLL    = 1,
    parameter int unsigned TAG_W     = 32,
    parameter bit          DOUBLE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MSG_W-1:0]  in_msg,
    input  logic [HASH_W-1:0] in_h,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_double,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HASH_W-1:0] out_h,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned EXT_N = 16 + UNROLL;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("sha256_iter_core: UNROLL must be 1, 2, 4 or 8");
    end

    state_t           state;
    state_t           state_nxt;
    work_t            work;
    work_t            h_chain;
    word_t            w_win [16];
    logic [CNT_W-1:0] cnt;
    logic             dbl_pend;
    logic [TAG_W-1:0] tag_q;

    word_t            ext_c [EXT_N];
    work_t            stage_c [UNROLL];
    work_t            digest_c;
    logic             last_round_c;

    // Window W[t..t+15] extended by UNROLL fresh words; new words chain within the cycle.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ext_c[i] = w_win[i];
        end
        for (int j = 0; j < int'(UNROLL); j++) begin
            ext_c[16+j] = ssig1(ext_c[14+j]) + ext_c[9+j] + ssig0(ext_c[1+j]) + ext_c[j];
        end
    end

    for (genvar r = 0; r < int'(UNROLL); r++) begin : g_round
        if (r == 0) begin : g_first
            sha256_round_comb u_round (
                .cur   (work),
                .k     (K[cnt]),
                .w     (ext_c[0]),
                .nxt_c (stage_c[0])
            );
        end else begin : g_next
            sha256_round_comb u_round (
                .cur   (stage_c[r-1]),
                .k     (K[cnt + CNT_W'(r)]),
                .w     (ext_c[r]),
                .nxt_c (stage_c[r])
            );
        end
    end

    assign last_round_c = (cnt == CNT_W'(ROUNDS - UNROLL));
    assign digest_c     = add_work(h_chain, work);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_ROUND;
            ST_ROUND: if (last_round_c) state_nxt = ST_FINAL;
            ST_FINAL: state_nxt = dbl_pend ? ST_ROUND : ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == ST_IDLE);
            out_valid <= (state_nxt == ST_DONE);
        end
    end

    // Datapath: job capture, round iteration, feed-forward and second-pass reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work     <= '0;
            h_chain  <= '0;
            cnt      <= '0;
            dbl_pend <= 1'b0;
            tag_q    <= '0;
            out_h    <= '0;
            out_tag  <= '0;
            for (int i = 0; i < 16; i++) begin
                w_win[i] <= '0;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work     <= work_t'(in_h);
                        h_chain  <= work_t'(in_h);
                        tag_q    <= in_tag;
                        dbl_pend <= DOUBLE_EN && in_double;
                        cnt      <= '0;
                        for (int i = 0; i < 16; i++) begin
                            w_win[i] <= in_msg[MSG_W-1-WORD_W*i -: WORD_W];
                        end
                    end
                end
                ST_ROUND: begin
                    work <= stage_c[UNROLL-1];
                    cnt  <= cnt + CNT_W'(UNROLL);
                    for (int i = 0; i < 16; i++) begin
                        w_win[i] <= ext_c[int'(UNROLL)+i];
                    end
                end
                ST_FINAL: begin
                    if (dbl_pend) begin
                        work     <= IV;
                        h_chain  <= IV;
                        cnt      <= '0;
                        dbl_pend <= 1'b0;
                        for (int i = 0; i < 8; i++) begin
                            w_win[i] <= digest_c[HASH_W-1-WORD_W*i -: WORD_W];
                        end
                        w_win[8] <= 32'h8000_0000;
                        for (int i = 9; i < 15; i++) begin
                            w_win[i] <= '0;
                        end
                        w_win[15] <= 32'h0000_0100;
                    end else begin
                        out_h   <= digest_c;
                        out_tag <= tag_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_iter_core.sv
// Bench for sha256_iter_core: four instances (UNROLL 4/1/8/8, one with the
// second pass disabled) checked against known SHA-256 / sha256d digests.
module tb_sha256_iter_core;

    localparam logic [511:0] ABC      = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY    = {32'h80000000, 480'h0};
    localparam logic [255:0] IVH      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_D    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_D  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] ABC_DD   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
    localparam logic [255:0] EMPTY_DD = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;

    typedef struct {
        int           g;
        logic [511:0] msg;
        logic         dbl;
        logic [31:0]  tag;
        logic [255:0] exp_h;
        int           lat;
    } vec_t;

    typedef struct {
        logic [255:0] h;
        logic [31:0]  tag;
        int           acc;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] msg;
    logic [255:0] hin;
    logic [31:0]  tag;
    logic         dbl;
    logic         in_valid  [4];
    logic         out_ready [4];
    logic         in_ready  [4];
    logic         out_valid [4];
    logic [255:0] out_h     [4];
    logic [31:0]  out_tag   [4];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    vec_t vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned U  = (g == 0) ? 4 : (g == 1) ? 1 : 8;
        localparam bit          DE = (g == 2) ? 1'b0 : 1'b1;
        sha256_iter_core #(.UNROLL(U), .TAG_W(32), .DOUBLE_EN(DE)) dut (
            .clk       (clk),
            .reset     (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_msg    (msg),
            .in_h      (hin),
            .in_tag    (tag),
            .in_double (dbl),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_h     (out_h[g]),
            .out_tag   (out_tag[g])
        );
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Offer a job once the instance is ready; expectation queued as it is driven.
    task automatic drive(input int g, input logic [511:0] m, input logic d,
                         input logic [31:0] t, input logic [255:0] eh, input int lat);
        int n = 0;
        while (!in_ready[g] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[g]) begin
            chk("drive_timeout", 256'(in_ready[g]), 256'd1);
            return;
        end
        msg = m; hin = IVH; tag = t; dbl = d;
        in_valid[g] = 1'b1;
        sbq.push_back('{eh, t, cyc + 1, lat});
        @(negedge clk);
        in_valid[g] = 1'b0;
    endtask

    task automatic collect(input int g);
        exp_t e;
        int   n = 0;
        while (!out_valid[g] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid[g]) begin
            chk("out_timeout", 256'(out_valid[g]), 256'd1);
            if (sbq.size() > 0) void'(sbq.pop_front());
            return;
        end
        if (sbq.size() == 0) begin
            chk("unexpected_out", 256'(out_valid[g]), 256'd0);
            return;
        end
        e = sbq.pop_front();
        chk("latency", 256'(cyc - e.acc), 256'(e.lat));
        chk("digest", out_h[g], e.h);
        chk("tag", 256'(out_tag[g]), 256'(e.tag));
        out_ready[g] = 1'b1;
        @(negedge clk);
        out_ready[g] = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1;
        msg = '0; hin = '0; tag = '0; dbl = 1'b0;
        for (int g = 0; g < 4; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
        end
        vecs[0] = '{1, ABC,   1'b0, 32'hDEADBEEF, ABC_D,    65};
        vecs[1] = '{0, EMPTY, 1'b0, 32'h00000001, EMPTY_D,  17};
        vecs[2] = '{3, ABC,   1'b1, 32'hCAFE0001, ABC_DD,   18};
        vecs[3] = '{2, ABC,   1'b1, 32'hCAFE0002, ABC_D,    9};
        vecs[4] = '{0, ABC,   1'b1, 32'hCAFE0003, ABC_DD,   34};
        vecs[5] = '{3, EMPTY, 1'b1, 32'hCAFE0004, EMPTY_DD, 18};
        vecs[6] = '{2, EMPTY, 1'b0, 32'hCAFE0005, EMPTY_D,  9};
        vecs[7] = '{1, EMPTY, 1'b1, 32'hCAFE0006, EMPTY_DD, 130};

        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("rst_in_ready", 256'(in_ready[g]), 256'd1);
            chk("rst_out_valid", 256'(out_valid[g]), 256'd0);
            chk("rst_out_h", out_h[g], 256'd0);
            chk("rst_out_tag", 256'(out_tag[g]), 256'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].g, vecs[i].msg, vecs[i].dbl, vecs[i].tag, vecs[i].exp_h, vecs[i].lat);
            collect(vecs[i].g);
        end

        // Backpressure: result held for 10 cycles while a second job waits.
        drive(0, EMPTY, 1'b0, 32'h000000A1, EMPTY_D, 17);
        n = 0;
        while (!out_valid[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", 256'(out_valid[0]), 256'd1);
        e = sbq.pop_front();
        chk("bp_latency", 256'(cyc - e.acc), 256'd17);
        msg = ABC; hin = IVH; tag = 32'h000000B2; dbl = 1'b0;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 256'(out_valid[0]), 256'd1);
            chk("bp_hold_h", out_h[0], EMPTY_D);
            chk("bp_hold_tag", 256'(out_tag[0]), 256'h000000A1);
            chk("bp_hold_ready", 256'(in_ready[0]), 256'd0);
        end
        sbq.push_back('{ABC_D, 32'h000000B2, cyc + 2, 17});
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("bp_release_valid", 256'(out_valid[0]), 256'd0);
        chk("bp_release_ready", 256'(in_ready[0]), 256'd1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("bp_second_busy", 256'(in_ready[0]), 256'd0);
        collect(0);

        // Asynchronous reset in the middle of ROUND aborts the job.
        drive(0, EMPTY, 1'b1, 32'h00000055, EMPTY_DD, 34);
        repeat (5) @(negedge clk);
        chk("mid_busy", 256'(in_ready[0]), 256'd0);
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 256'(in_ready[0]), 256'd1);
        chk("arst_out_valid", 256'(out_valid[0]), 256'd0);
        chk("arst_out_h", out_h[0], 256'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(0, ABC, 1'b0, 32'h00000077, ABC_D, 17);
        collect(0);

        // Back-to-back jobs, consumer always ready.
        fork
            begin
                drive(0, ABC,   1'b0, 32'd1, ABC_D,   17);
                drive(0, EMPTY, 1'b0, 32'd2, EMPTY_D, 17);
                drive(0, ABC,   1'b1, 32'd3, ABC_DD,  34);
            end
            begin
                collect(0);
                collect(0);
                collect(0);
            end
        join
        chk("sb_empty", 256'(sbq.size()), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_iter_core.md
Name: sha256_iter_core

Overview:
Iterative SHA-256 compression core with a configurable unroll factor: it computes UNROLL rounds per clock, so one 512-bit block takes 64/UNROLL round cycles.
- Replaces fixed-depth unrolled pipelines where area matters; several instances can sit behind the miner's work dispatcher.
- Adds valid/ready handshakes, an opaque tag (nonce) carried through unchanged, and an optional double-SHA (Bitcoin sha256d) mode executed in the same datapath.

Parameters:
UNROLL, 1, rounds per clock; legal values 1, 2, 4, 8; any other value is an elaboration error.
TAG_W, 32, width of the tag/nonce passed through with each job.
DOUBLE_EN, 1, 1 = in_double honoured; 0 = in_double ignored and the second-pass logic is removed.

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-high reset
in_valid  in  1  job offered
in_ready  out  1  core can accept a job
in_msg  in  512  message block; word W0 = [511:480], W15 = [31:0]
in_h  in  256  chaining value; a = [255:224], h = [31:0]
in_tag  in  TAG_W  opaque tag (nonce)
in_double  in  1  1 = sha256d: after pass 1, hash the 256-bit digest again from the standard IV
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_h  out  256  digest, same word order as in_h
out_tag  out  TAG_W  tag captured with the job

Behaviour:
- Reset (asynchronous assert): state = IDLE; in_ready = 1; out_valid = 0; out_h = 0; out_tag = 0; all working and schedule registers = 0. Reset during any state aborts the job with no output.
- States:
  - IDLE: in_ready = 1. On in_valid: capture msg/h/tag/double; load a..h from in_h; W window from in_msg; round counter = 0; go to ROUND.
  - ROUND: each cycle apply UNROLL chained rounds using K[cnt..cnt+UNROLL-1] and the 16-word sliding W window, extended by UNROLL words per cycle; cnt += UNROLL. After the cycle in which cnt reaches 64-UNROLL, go to FINAL.
  - FINAL (1 cycle): digest = H_chain + {a..h}, word-wise mod 2^32.
    - If double is pending (in_double = 1 and DOUBLE_EN = 1, pass 1 only): load W = {digest, 0x80000000, six 0x0 words, 0x00000100}; load H_chain and a..h = standard IV (6a09e667 … 5be0cd19); cnt = 0; go to ROUND (pass 2).
    - Otherwise: register digest to out_h, assert out_valid, go to DONE.
  - DONE: out_valid = 1; out_h and out_tag held stable. On out_ready go to IDLE. in_ready = 0 here; a new job is accepted no earlier than the cycle after the output handshake.
- Timing:
  - in_ready = 1 only in IDLE; in_valid in any other state is ignored and must be held by the source.
  - Latency from the accepting edge to out_valid high: 64/UNROLL+1 cycles (single), 2*(64/UNROLL+1) cycles (double). Example for UNROLL = 4: 17 / 34.
  - Throughput: one job per latency + 2 cycles.
- Arithmetic:
  - All additions are 32-bit modulo 2^32.
  - Σ0, Σ1, σ0, σ1, Ch and Maj follow FIPS 180-4.
  - Schedule: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] for t ≥ 16. Words produced within the same cycle feed later rounds in that cycle combinationally.
- Output holding: out_h and out_tag change only at the FINAL→DONE edge. out_valid never deasserts without out_ready.

Decomposition:
- Shared header sha.vh (already included across the miner): WORD_S, the K[0..63] constant table, the IV constants, and the σ/Σ/Ch/Maj function macros.
- Sub-module sha256_round_comb: purely combinational single round, taking {a..h, K, W} and producing the next {a..h}. The core instantiates UNROLL of these in a chain.
- Schedule extension and the FSM stay in the core.

Test Plan:
- UNROLL = 1 single block, "abc" padded (W0 = 61626380, W15 = 00000018), IV, tag = 0xDEADBEEF → out_h = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_tag = DEADBEEF, out_valid exactly 65 cycles after acceptance.
- UNROLL = 4, empty-message block (W0 = 80000000, remaining words 0) → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at latency 17.
- UNROLL = 8, in_double = 1, "abc" block → 4f8b42c2 2dd3729b 519ba6f6 8d2da7cc 5b2d606d 05daed5a d5128cc0 3e6c6358 at latency 18. With DOUBLE_EN = 0 the same stimulus → the single-pass "abc" digest.
- Backpressure: hold out_ready = 0 for 10 cycles → out_valid, out_h and out_tag stable; in_ready = 0 and a second in_valid is not accepted. Release → second job accepted the cycle after the output handshake, and its result is correct.
- Reset asserted mid-ROUND (cycle 5) → asynchronously out_valid = 0 and in_ready = 1. A subsequent "abc" job → correct digest with no residue from the aborted job.
- Back-to-back jobs with distinct tags 1, 2, 3 and out_ready = 1 → results returned in order with matching tags.
